fastclk_sel_ctrl: RTL and testbench
===================================

// Module: fastclk_sel_ctrl
// PURPOSE
//   Sequencer and health monitor for the fast-clock source mux (external 6.5536 MHz vs
//   5 MHz divided from 50 MHz). Runs on the 50 MHz system clock.
//   Qualifies the external clock by counting its edges per window. Drives the mux
//   select, and gates downstream fast-clock consumers off while the select changes.
//   Falls back to the divided clock automatically when the external clock is lost.
// PARAMETERS
//   WINDOW_CYCLES  1024  clk cycles per edge-count window (≈20.48 us)
//   MIN_EDGES      120   minimum ext rising edges per window for a good window (nominal 134)
//   MAX_EDGES      150   maximum ext rising edges per window for a good window
//   GOOD_WINDOWS   4     consecutive good windows required before ext_ok asserts
//   QUIET_CYCLES   16    gate-off cycles before and after a select change (>=1)
// PORTS
//   clk            in   1   50 MHz system clock
//   rst_n          in   1   reset, asynchronous, active-low
//   ext_clk_in     in   1   raw external fast clock, asynchronous to clk (monitored only)
//   sel_req_ext    in   1   1 = prefer external clock, 0 = prefer divided clock
//   force_div      in   1   1 = force divided clock, overrides sel_req_ext
//   fast_clk_sel   out  1   mux select: 1 = external, 0 = divided
//   fast_clk_en    out  1   1 = downstream fast-clock consumers may run
//   busy           out  1   1 = switch sequence in progress (state != RUN)
//   ext_ok         out  1   external clock qualified
//   fallback_evt   out  1   one-cycle pulse: external lost while selected
//   edge_count     out  16  ext rising edges counted in the last completed window
// BEHAVIOUR
//   Reset (async, all outputs registered):
//   - state=SETTLE, timer=QUIET_CYCLES-1
//   - fast_clk_sel=0, fast_clk_en=0, busy=1, ext_ok=0, fallback_evt=0, edge_count=0
//   - Synchronizer, window counter and good-run counter cleared.
//   Monitor:
//   - ext_clk_in passes through a 2-FF synchronizer, then rising-edge detect (3rd FF).
//   - The edge counter saturates at 16'hFFFF.
//   - The window counter runs 0..WINDOW_CYCLES-1 and wraps.
//   - At the terminal count: edge_count <= count (including any edge in that cycle), and
//     the edge counter restarts at 0.
//   - A window is good when MIN_EDGES <= count <= MAX_EDGES.
//   - On a good window, good_run increments, saturating at GOOD_WINDOWS. On a bad window,
//     good_run clears to 0.
//   - ext_ok = (good_run == GOOD_WINDOWS), registered. It drops on the cycle after the
//     first bad window ends.
//   - target = sel_req_ext & ext_ok & ~force_div, evaluated every cycle.
//   FSM:
//   - RUN: fast_clk_en=1.
//     - If target != fast_clk_sel: next GATE, timer <= QUIET_CYCLES-1, fast_clk_en <= 0.
//     - If, in that same cycle, fast_clk_sel=1 and ext_ok=0: fallback_evt <= 1 for one
//       cycle.
//   - GATE: timer decrements; at 0, next SWITCH.
//   - SWITCH (1 cycle): fast_clk_sel <= target, sampled here. If target equals the
//     current select, nothing toggles. timer <= QUIET_CYCLES-1; next SETTLE.
//   - SETTLE: timer decrements. At 0:
//     - if target == fast_clk_sel: next RUN, fast_clk_en <= 1;
//     - else: next GATE directly, en stays 0.
//   Latency:
//   - target change seen in RUN at edge t gives fast_clk_en=0 at t+1.
//   - fast_clk_sel changes QUIET_CYCLES+1 cycles after en drops.
//   - en is low for 2*QUIET_CYCLES+1 cycles per switch.
//   Boundary rules:
//   - fast_clk_sel never changes while fast_clk_en=1.
//   - Requests toggling during GATE/SETTLE are resolved only at SWITCH or SETTLE exit;
//     there is no queueing.
//   - force_div and ext loss take effect through the same sequence; there is no bypass.
//   - rst_n low at any point, including mid-switch, returns all state to reset values at
//     once.
// TESTING
//   1. Release reset, inputs 0 -> en=0, sel=0, busy=1 for 16 cycles; en=1, busy=0 on
//      cycle 17.
//   2. ext_clk_in=6.5536 MHz, sel_req_ext=1 -> edge_count 133..135 per window; ext_ok
//      after 4 windows. Then en low for 33 cycles, sel=1 on en-low cycle 18, en=1 again.
//   3. From 2, stop ext_clk_in -> at next window end edge_count<120 and ext_ok=0;
//      fallback_evt pulses once; sel returns to 0 after gated sequence.
//   4. ext_clk_in=10 MHz (~205 edges/window) -> ext_ok never asserts; sel stays 0; no
//      en drop.
//   5. In RUN with sel=1, pulse force_div for 3 cycles during GATE -> SWITCH keeps sel=1;
//      en returns after 33 cycles; no fallback_evt.
//   6. Assert rst_n low mid-SETTLE with sel=1 -> sel=0, en=0, ext_ok=0 asynchronously;
//      restart matches test 1.

Source files
------------

// File: rtl/fastclk_sel_ctrl.sv
`timescale 1ns/1ps
// Fast-clock mux sequencer: qualifies ext clock by edges per window, switches the mux select inside a
// gated quiet period (en low 2*QUIET_CYCLES+1 cycles); no request queueing, falls back to divided clock on loss.
module fastclk_sel_ctrl #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int MIN_EDGES     = 120,
    parameter int MAX_EDGES     = 150,
    parameter int GOOD_WINDOWS  = 4,
    parameter int QUIET_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_clk_in,
    input  logic        sel_req_ext,
    input  logic        force_div,
    output logic        fast_clk_sel,
    output logic        fast_clk_en,
    output logic        busy,
    output logic        ext_ok,
    output logic        fallback_evt,
    output logic [15:0] edge_count
);
    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int TMR_W = $clog2(QUIET_CYCLES + 1);
    localparam int GR_W  = $clog2(GOOD_WINDOWS + 1);

    localparam logic [WIN_W-1:0] WIN_MAX   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_INIT  = TMR_W'(QUIET_CYCLES - 1);
    localparam logic [GR_W-1:0]  GR_MAX    = GR_W'(GOOD_WINDOWS);
    localparam logic [15:0]      MIN_E     = 16'(MIN_EDGES);
    localparam logic [15:0]      MAX_E     = 16'(MAX_EDGES);

    typedef enum logic [1:0] {RUN, GATE, SWITCH, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             sel_q, sel_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             fb_q, fb_d;
    logic             ext_ok_q, ext_ok_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic             sync1_d, sync2_d, sync3_d;
    logic [15:0]      edge_cnt_q, edge_cnt_d;
    logic [15:0]      edge_count_q, edge_count_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;

    logic        rise;
    logic        win_end;
    logic        win_good;
    logic [15:0] edge_inc;
    logic        target;

    // Edge monitor: synchronize, detect rising edges, close a window every WINDOW_CYCLES.
    always_comb begin
        sync1_d  = ext_clk_in;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        rise     = sync2_q & ~sync3_q;
        edge_inc = (edge_cnt_q == 16'hFFFF) ? edge_cnt_q : edge_cnt_q + {15'd0, rise};
        win_end  = (win_cnt_q == WIN_MAX);
        win_good = (edge_inc >= MIN_E) && (edge_inc <= MAX_E);

        win_cnt_d    = win_end ? '0 : win_cnt_q + 1'b1;
        edge_cnt_d   = win_end ? 16'd0 : edge_inc;
        edge_count_d = win_end ? edge_inc : edge_count_q;
        good_run_d   = good_run_q;
        if (win_end) begin
            if (!win_good) begin
                good_run_d = '0;
            end else if (good_run_q != GR_MAX) begin
                good_run_d = good_run_q + 1'b1;
            end
        end
        ext_ok_d = (good_run_d == GR_MAX);
    end

    assign target = sel_req_ext & ext_ok_q & ~force_div;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        en_d    = en_q;
        fb_d    = 1'b0;
        unique case (state_q)
            RUN: begin
                en_d = 1'b1;
                if (target != sel_q) begin
                    state_d = GATE;
                    timer_d = TMR_INIT;
                    en_d    = 1'b0;
                    fb_d    = sel_q & ~ext_ok_q;
                end
            end
            GATE: begin
                if (timer_q == '0) state_d = SWITCH;
                else               timer_d = timer_q - 1'b1;
            end
            SWITCH: begin
                sel_d   = target;
                timer_d = TMR_INIT;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (target == sel_q) begin
                    state_d = RUN;
                    en_d    = 1'b1;
                end else begin
                    // Request flipped while gated: go straight back into another quiet period.
                    state_d = GATE;
                    timer_d = TMR_INIT;
                end
            end
            default: begin
                state_d = SETTLE;
                timer_d = TMR_INIT;
                en_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SETTLE;
            timer_q      <= TMR_INIT;
            sel_q        <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b1;
            fb_q         <= 1'b0;
            ext_ok_q     <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            edge_cnt_q   <= 16'd0;
            edge_count_q <= 16'd0;
            win_cnt_q    <= '0;
            good_run_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            fb_q         <= fb_d;
            ext_ok_q     <= ext_ok_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            edge_cnt_q   <= edge_cnt_d;
            edge_count_q <= edge_count_d;
            win_cnt_q    <= win_cnt_d;
            good_run_q   <= good_run_d;
        end
    end

    assign fast_clk_sel = sel_q;
    assign fast_clk_en  = en_q;
    assign busy         = busy_q;
    assign ext_ok       = ext_ok_q;
    assign fallback_evt = fb_q;
    assign edge_count   = edge_count_q;
endmodule

// File: tb/tb_fastclk_sel_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for fastclk_sel_ctrl: stimulus queues expected gate episodes, ext_ok changes
// and state snapshots; a monitor on the falling clock edge pops and compares them.
module tb_fastclk_sel_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_clk_in = 1'b0;
    logic        sel_req_ext = 1'b0;
    logic        force_div = 1'b0;
    logic        fast_clk_sel, fast_clk_en, busy, ext_ok, fallback_evt;
    logic [15:0] edge_count;

    fastclk_sel_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ext_clk_in(ext_clk_in), .sel_req_ext(sel_req_ext),
        .force_div(force_div), .fast_clk_sel(fast_clk_sel), .fast_clk_en(fast_clk_en),
        .busy(busy), .ext_ok(ext_ok), .fallback_evt(fallback_evt), .edge_count(edge_count)
    );

    initial forever #10 clk = ~clk;

    bit  ext_on = 1'b0;
    real ext_half = 76.294;
    initial forever begin
        if (ext_on) begin
            #(ext_half) ext_clk_in = ~ext_clk_in;
        end else begin
            ext_clk_in = 1'b0;
            #7;
        end
    end

    typedef struct { int len; int chg; bit sel; int fb; } ep_t;
    typedef struct { bit val; int lo; int hi; } ok_t;
    typedef struct { bit en; bit sel; bit ok; bit bsy; int lo; int hi; } snap_t;

    ep_t   q_ep[$];
    ok_t   q_ok[$];
    snap_t q_snap[$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic check(input bit good, input string name, input string info);
        n_chk++;
        if (!good) begin
            n_fail++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    function automatic ep_t mk_ep(int len, int chg, bit sel, int fb);
        ep_t e;
        e.len = len; e.chg = chg; e.sel = sel; e.fb = fb;
        return e;
    endfunction

    function automatic ok_t mk_ok(bit val, int lo, int hi);
        ok_t o;
        o.val = val; o.lo = lo; o.hi = hi;
        return o;
    endfunction

    function automatic snap_t mk_snap(bit en, bit sel, bit ok, bit bsy, int lo, int hi);
        snap_t s;
        s.en = en; s.sel = sel; s.ok = ok; s.bsy = bsy; s.lo = lo; s.hi = hi;
        return s;
    endfunction

    // Monitor: an episode is a run of en-low cycles closed by en rising again.
    initial begin
        int len, chg, fb;
        bit pen, psel, pok;
        len = 0; chg = 0; fb = 0; pen = 0; psel = 0; pok = 0;
        forever begin
            @(negedge clk);
            if (q_snap.size() > 0) begin
                snap_t s;
                s = q_snap.pop_front();
                check(fast_clk_en == s.en && fast_clk_sel == s.sel && ext_ok == s.ok && busy == s.bsy &&
                      int'(edge_count) >= s.lo && int'(edge_count) <= s.hi, "snapshot",
                      $sformatf("got en=%0b sel=%0b ok=%0b busy=%0b ec=%0d, want en=%0b sel=%0b ok=%0b busy=%0b ec=%0d..%0d",
                                fast_clk_en, fast_clk_sel, ext_ok, busy, edge_count,
                                s.en, s.sel, s.ok, s.bsy, s.lo, s.hi));
            end
            if (!rst_n) begin
                len = 0; chg = 0; fb = 0; pen = 0; psel = 0; pok = 0;
            end else begin
                if (fallback_evt) fb++;
                if (!fast_clk_en) begin
                    len++;
                    if (fast_clk_sel != psel) chg = len;
                end else if (fast_clk_sel != psel) begin
                    check(1'b0, "sel_while_en", $sformatf("sel changed to %0b with en=1", fast_clk_sel));
                end
                if (fast_clk_en && !pen) begin
                    if (q_ep.size() == 0) begin
                        check(1'b0, "unexpected_episode", $sformatf("len=%0d chg=%0d sel=%0b fb=%0d", len, chg, fast_clk_sel, fb));
                    end else begin
                        ep_t e;
                        e = q_ep.pop_front();
                        check(len == e.len && chg == e.chg && fast_clk_sel == e.sel && fb == e.fb, "episode",
                              $sformatf("got len=%0d chg=%0d sel=%0b fb=%0d, want len=%0d chg=%0d sel=%0b fb=%0d",
                                        len, chg, fast_clk_sel, fb, e.len, e.chg, e.sel, e.fb));
                    end
                    len = 0; chg = 0; fb = 0;
                end
                if (ext_ok != pok) begin
                    if (q_ok.size() == 0) begin
                        check(1'b0, "unexpected_ext_ok", $sformatf("ext_ok=%0b ec=%0d", ext_ok, edge_count));
                    end else begin
                        ok_t o;
                        o = q_ok.pop_front();
                        check(ext_ok == o.val && int'(edge_count) >= o.lo && int'(edge_count) <= o.hi, "ext_ok_change",
                              $sformatf("got ok=%0b ec=%0d, want ok=%0b ec=%0d..%0d", ext_ok, edge_count, o.val, o.lo, o.hi));
                    end
                end
                pen = fast_clk_en; psel = fast_clk_sel; pok = ext_ok;
            end
        end
    end

    // kind 0: ext_ok==v, 1: sel==v, 2: (en & ~busy)==v
    task automatic wait_for(input int kind, input bit v, input int budget, input string name);
        int  n;
        bit  hit;
        n = 0; hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (kind)
                0:       hit = (ext_ok == v);
                1:       hit = (fast_clk_sel == v);
                default: hit = ((fast_clk_en && !busy) == v);
            endcase
        end
        if (!hit) check(1'b0, name, $sformatf("timeout after %0d cycles", budget));
    endtask

    initial begin
        // 1: reset state, then 16 gated cycles before RUN.
        q_snap.push_back(mk_snap(0, 0, 0, 1, 0, 0));
        q_ep.push_back(mk_ep(16, 0, 0, 0));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_for(2, 1'b1, 100, "t1_idle");

        // 2: nominal external clock qualifies, then switch to it.
        q_ok.push_back(mk_ok(1, 133, 135));
        q_ep.push_back(mk_ep(33, 18, 1, 0));
        ext_half = 76.294;
        ext_on = 1'b1;
        sel_req_ext = 1'b1;
        wait_for(0, 1'b1, 8000, "t2_ext_ok");
        wait_for(1, 1'b1, 100, "t2_sel");
        wait_for(2, 1'b1, 100, "t2_idle");
        q_snap.push_back(mk_snap(1, 1, 1, 0, 133, 135));

        // 3: external clock lost while selected.
        q_ok.push_back(mk_ok(0, 0, 119));
        q_ep.push_back(mk_ep(33, 18, 0, 1));
        ext_on = 1'b0;
        wait_for(0, 1'b0, 3000, "t3_ext_lost");
        wait_for(1, 1'b0, 100, "t3_sel");
        wait_for(2, 1'b1, 100, "t3_idle");
        q_snap.push_back(mk_snap(1, 0, 0, 0, 0, 119));

        // 4: 10 MHz is too fast to qualify.
        ext_half = 50.0;
        ext_on = 1'b1;
        repeat (5 * 1024) @(negedge clk);
        q_snap.push_back(mk_snap(1, 0, 0, 0, 200, 210));

        // 5: requalify, then a short force_div during GATE leaves sel at 1.
        q_ok.push_back(mk_ok(1, 133, 135));
        q_ep.push_back(mk_ep(33, 18, 1, 0));
        ext_half = 76.294;
        wait_for(0, 1'b1, 8000, "t5_ext_ok");
        wait_for(1, 1'b1, 100, "t5_sel");
        wait_for(2, 1'b1, 100, "t5_idle");
        q_ep.push_back(mk_ep(33, 0, 1, 0));
        @(posedge clk);
        #1 force_div = 1'b1;
        repeat (3) @(posedge clk);
        #1 force_div = 1'b0;
        wait_for(2, 1'b1, 100, "t5_force_idle");
        q_snap.push_back(mk_snap(1, 1, 1, 0, 133, 135));

        // 6: reset asserted mid-SETTLE with sel=1.
        @(posedge clk);
        #1 force_div = 1'b1;
        @(posedge clk);
        #1 force_div = 1'b0;
        repeat (25) @(posedge clk);
        #3 rst_n = 1'b0;
        q_snap.push_back(mk_snap(0, 0, 0, 1, 0, 0));
        q_ep.push_back(mk_ep(16, 0, 0, 0));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_for(2, 1'b1, 100, "t6_idle");
        repeat (20) @(negedge clk);
        check(q_ep.size() == 0 && q_ok.size() == 0 && q_snap.size() == 0, "queues_drained",
              $sformatf("left ep=%0d ok=%0d snap=%0d, want 0", q_ep.size(), q_ok.size(), q_snap.size()));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
